// File: rtl/debug_scanner.sv
// Debug scanner: single-steps a core through its debug port, then reads the
// debug register window address by address and streams each word to a sink.
module debug_scanner #(
  parameter int         STEP_HIGH  = 2,
  parameter int         STEP_LOW   = 2,
  parameter int         SETTLE     = 1,
  parameter logic [6:0] SCAN_FIRST = 7'd0,
  parameter logic [6:0] SCAN_LAST  = 7'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_steps,
  input  logic        cmd_run,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [6:0]  out_addr,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, STEP_HI, STEP_LO, SETTLE_W, SEND} state_t;

  // Terminal values of the shared phase counter for each timed state.
  localparam logic [15:0] HI_END  = 16'(STEP_HIGH - 1);
  localparam logic [15:0] LO_END  = 16'(STEP_LOW - 1);
  localparam logic [15:0] SET_END = 16'(SETTLE);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  steps_q, steps_d;
  logic        en_q, en_d;
  logic        step_q, step_d;
  logic [6:0]  addr_q, addr_d;
  logic        ovalid_q, ovalid_d;
  logic [31:0] odata_q, odata_d;
  logic [6:0]  oaddr_q, oaddr_d;
  logic        olast_q, olast_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      steps_q  <= '0;
      en_q     <= 1'b0;
      step_q   <= 1'b0;
      addr_q   <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      oaddr_q  <= '0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      en_q     <= en_d;
      step_q   <= step_d;
      addr_q   <= addr_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      oaddr_q  <= oaddr_d;
      olast_q  <= olast_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    steps_d  = steps_q;
    en_d     = en_q;
    step_d   = step_q;
    addr_d   = addr_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    oaddr_d  = oaddr_q;
    olast_d  = olast_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_run) begin
            en_d = 1'b0;
          end else begin
            en_d    = 1'b1;
            steps_d = cmd_steps;
            cnt_d   = '0;
            if (cmd_steps != 8'd0) begin
              state_d = STEP_HI;
              step_d  = 1'b1;
            end else begin
              state_d = SETTLE_W;
              addr_d  = SCAN_FIRST;
            end
          end
        end
      end
      STEP_HI: begin
        if (cnt_q == HI_END) begin
          state_d = STEP_LO;
          step_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STEP_LO: begin
        if (cnt_q == LO_END) begin
          steps_d = steps_q - 8'd1;
          cnt_d   = '0;
          // steps_q still holds the pre-decrement count here.
          if (steps_q != 8'd1) begin
            state_d = STEP_HI;
            step_d  = 1'b1;
          end else begin
            state_d = SETTLE_W;
            addr_d  = SCAN_FIRST;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SETTLE_W: begin
        if (cnt_q == SET_END) begin
          state_d  = SEND;
          cnt_d    = '0;
          ovalid_d = 1'b1;
          odata_d  = debug_data;
          oaddr_d  = addr_q;
          olast_d  = (addr_q == SCAN_LAST);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SEND: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          if (olast_q) begin
            state_d = IDLE;
          end else begin
            state_d = SETTLE_W;
            addr_d  = addr_q + 7'd1;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign debug_en   = en_q;
  assign debug_step = step_q;
  assign debug_addr = addr_q;
  assign out_valid  = ovalid_q;
  assign out_data   = odata_q;
  assign out_addr   = oaddr_q;
  assign out_last   = olast_q;

endmodule

// File: tb/tb_debug_scanner.sv
// Directed bench for debug_scanner: default-parameter scans plus a single-word
// window instance with asymmetric step/settle timing.
module tb_debug_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_steps = 8'd0;
  logic        cmd_run = 1'b0;
  logic        debug_en, debug_step;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [6:0]  out_addr;
  logic        out_last, busy;
  logic        data_mode = 1'b0;

  logic        cmd_valid1 = 1'b0;
  logic        cmd_ready1, debug_en1, debug_step1, out_valid1, out_last1, busy1;
  logic [6:0]  debug_addr1, out_addr1;
  logic [31:0] debug_data1, out_data1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  always #5 clk = ~clk;

  // Core register file models: data is a pure function of the address.
  assign debug_data  = data_mode ? {debug_addr, 25'h1ABCDE5} : {25'h0, debug_addr};
  assign debug_data1 = {25'h0, debug_addr1} ^ 32'hDEAD0000;

  debug_scanner dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_run(cmd_run), .debug_en(debug_en),
    .debug_step(debug_step), .debug_addr(debug_addr), .debug_data(debug_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy)
  );

  debug_scanner #(.STEP_HIGH(1), .STEP_LOW(3), .SETTLE(3),
                  .SCAN_FIRST(7'd100), .SCAN_LAST(7'd100)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_steps(cmd_steps), .cmd_run(cmd_run), .debug_en(debug_en1),
    .debug_step(debug_step1), .debug_addr(debug_addr1), .debug_data(debug_data1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_data(out_data1),
    .out_addr(out_addr1), .out_last(out_last1), .busy(busy1)
  );

  always @(posedge clk) if (rst && cmd_valid && cmd_ready) n_acc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input int a);
    logic [6:0] a7;
    a7 = a[6:0];
    return data_mode ? {a7, 25'h1ABCDE5} : {25'h0, a7};
  endfunction

  task automatic issue(input logic [7:0] steps, input logic run);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_steps = steps;
    cmd_run   = run;
    tick();
    cmd_valid = 1'b0;
    cmd_run   = 1'b0;
  endtask

  // Collects the 32-word scan; exp_lat < 0 skips the first-word latency check.
  task automatic scan(input int exp_lat, input int stall_word);
    int idx = 0;
    int cyc = 0;
    int last_acc = 0;
    int stalled = 0;
    bit fresh = 1'b1;
    while (idx < 32 && cyc < 600) begin
      if (out_valid) begin
        if (fresh) begin
          if (idx == 0) begin
            if (exp_lat >= 0) check("first_latency", cyc, exp_lat);
          end else begin
            check("word_gap", cyc - last_acc, 3);
          end
          fresh = 1'b0;
        end
        if (idx == stall_word && stalled < 10) begin
          out_ready = 1'b0;
          stalled++;
          check("stall_out_addr", {25'h0, out_addr}, idx);
          check("stall_debug_addr", {25'h0, debug_addr}, idx);
          check("stall_out_data", out_data, model(idx));
        end else begin
          out_ready = 1'b1;
          check("word_addr", {25'h0, out_addr}, idx);
          check("word_data", out_data, model(idx));
          check("word_last", out_last, (idx == 31));
          idx++;
          last_acc = cyc;
          fresh = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    check("scan_word_count", idx, 32);
    check("scan_end_busy", busy, 0);
    check("scan_end_valid", out_valid, 0);
    check("scan_end_debug_en", debug_en, 1);
  endtask

  initial begin
    int rises;
    logic prev;
    logic [11:0] pat;
    int acc0;
    int words;

    // Reset state
    rst = 1'b0;
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_debug_en", debug_en, 0);
    check("rst_debug_step", debug_step, 0);
    check("rst_debug_addr", {25'h0, debug_addr}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", {25'h0, out_addr}, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b1;
    tick();

    // Three step pulses, 2 high / 2 low, then full scan
    data_mode = 1'b1;
    issue(8'd3, 1'b0);
    check("a_debug_en", debug_en, 1);
    pat = 12'b110011001100;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("a_step_%0d", k), debug_step, pat[11 - k]);
      check("a_busy", busy, 1);
      tick();
    end
    check("a_settle_addr", {25'h0, debug_addr}, 0);
    scan(2, -1);

    // Zero steps: scan starts immediately, out_data tracks address
    data_mode = 1'b0;
    tick();
    issue(8'd0, 1'b0);
    check("b_no_step", debug_step, 0);
    scan(2, -1);

    // Commands offered while busy are ignored; stall on word 5
    tick();
    issue(8'd2, 1'b0);
    acc0 = n_acc;
    for (int k = 0; k < 4; k++) begin
      cmd_valid = 1'b1;
      cmd_run   = 1'b1;
      check("c_cmd_ready_busy", cmd_ready, 0);
      tick();
    end
    cmd_valid = 1'b0;
    cmd_run   = 1'b0;
    check("c_accept_count", n_acc, acc0);
    check("c_debug_en_held", debug_en, 1);
    scan(6, 5);

    // Release to free-run after a scan
    tick();
    issue(8'd5, 1'b1);
    check("e_debug_en", debug_en, 0);
    check("e_busy", busy, 0);
    words = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid || debug_step) words++;
      tick();
    end
    check("e_no_activity", words, 0);

    // Reset during the second of four pulses
    issue(8'd4, 1'b0);
    rises = 0;
    prev = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (debug_step && !prev) rises++;
      prev = debug_step;
      if (k < 4) tick();
    end
    check("d_in_pulse2", debug_step, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("d_rises", rises, 2);
    check("d_step_dropped", debug_step, 0);
    check("d_debug_en", debug_en, 0);
    check("d_busy", busy, 0);
    check("d_cmd_ready", cmd_ready, 1);
    words = 0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid || debug_step) words++;
      tick();
    end
    check("d_no_word_after_reset", words, 0);

    // Single-address window, STEP_HIGH=1, STEP_LOW=3, SETTLE=3
    check("f_cmd_ready", cmd_ready1, 1);
    cmd_valid1 = 1'b1;
    cmd_steps  = 8'd1;
    tick();
    cmd_valid1 = 1'b0;
    check("f_step_s0", debug_step1, 1);
    tick();
    for (int k = 1; k < 4; k++) begin
      check("f_step_low", debug_step1, 0);
      check("f_busy", busy1, 1);
      tick();
    end
    check("f_settle_addr", {25'h0, debug_addr1}, 100);
    for (int k = 4; k < 8; k++) begin
      check("f_no_valid_yet", out_valid1, 0);
      tick();
    end
    check("f_valid", out_valid1, 1);
    check("f_out_addr", {25'h0, out_addr1}, 100);
    check("f_out_data", out_data1, 32'hDEAD0064);
    check("f_out_last", out_last1, 1);
    tick();
    check("f_done_valid", out_valid1, 0);
    check("f_done_busy", busy1, 0);
    check("f_done_debug_en", debug_en1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
